uart_cmd_sender: RTL and testbench
==================================

Name: uart_cmd_sender

Overview:
- Host-side counterpart of the robot's command receiver: accepts a 16-bit command, serializes it on TX as two 8N1 frames (high byte first, low byte second), then waits for the robot's 8-bit response byte.
- Contains its own baud-timed transmit shifter.
- The response byte arrives from a separate byte receiver via an rx_rdy/rx_data/clr_rx_rdy handshake.
- Sits between the host/test controller and the serial link.

Parameters:
- BAUD_DIV, 2604, clocks per serial bit (50 MHz / 19200 baud); must be >= 2.
- RESP_TIMEOUT, 1000000, clocks allowed in WAIT_RESP before giving up; must be >= 1.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- cmd  input  16  command to send; sampled only on the accept cycle
- snd_cmd  input  1  send request; accepted only in IDLE
- TX  output  1  serial line, idles high
- rx_rdy  input  1  byte receiver has a byte
- rx_data  input  8  byte from receiver
- clr_rx_rdy  output  1  one-cycle pulse acknowledging rx_rdy
- busy  output  1  high from the cycle after accept until the return to IDLE
- cmd_snt  output  1  one-cycle pulse when the low-byte stop bit completes
- resp  output  8  last response byte
- resp_rdy  output  1  response valid; held until the next accepted snd_cmd
- timeout  output  1  one-cycle pulse when the response wait expires

Behaviour:
- Clock and reset: clk; reset rst_n, asynchronous, active-low.
- Reset values:
  - TX=1; resp=8'h00.
  - busy, cmd_snt, resp_rdy, timeout, clr_rx_rdy all 0.
  - State IDLE; all counters 0.
  - Asserting reset mid-frame forces TX high immediately and abandons the command; no cmd_snt is issued.
- States: IDLE, TX_HIGH, TX_LOW, WAIT_RESP.
- IDLE:
  - snd_cmd=1 latches cmd into an internal 16-bit buffer, clears resp_rdy, and moves to TX_HIGH.
  - snd_cmd while not in IDLE is ignored; no queueing.
- Frame format: 10 bits: start 0, data[0]..data[7] LSB first, stop 1.
  - Each bit is driven for exactly BAUD_DIV clocks.
  - TX is registered: the start bit appears on TX the cycle after accept.
- TX_HIGH:
  - Sends buf[15:8].
  - After its stop bit completes, goes to TX_LOW with no idle gap.
  - The low-byte start bit begins on the next clock.
- TX_LOW:
  - Sends buf[7:0].
  - At the end of the stop bit, pulses cmd_snt for 1 cycle and enters WAIT_RESP.
  - TX stays 1 from here on.
  - Total clocks from accept to cmd_snt: 20*BAUD_DIV.
- WAIT_RESP:
  - Timeout counter starts at 0 and increments every clock.
  - If rx_rdy=1: resp<=rx_data, resp_rdy<=1, clr_rx_rdy pulses the same cycle, next state IDLE.
  - Else if the counter reaches RESP_TIMEOUT-1: pulse timeout, next state IDLE, resp unchanged.
  - rx_rdy and timeout expiry in the same cycle: the response wins and no timeout pulse is issued.
- Stale bytes: rx_rdy=1 in IDLE, TX_HIGH or TX_LOW gets clr_rx_rdy pulsed and the byte discarded; resp is unchanged.
- busy:
  - Rises the cycle after accept.
  - Falls the cycle the FSM re-enters IDLE.
  - snd_cmd is accepted again on the first IDLE cycle.
- Counter widths:
  - Baud counter: $clog2(BAUD_DIV) bits.
  - Bit counter: 4 bits.
  - Timeout counter: $clog2(RESP_TIMEOUT+1) bits.
  - No counter wraps within a state.

Test Plan:
- Reset with BAUD_DIV=4, RESP_TIMEOUT=50 -> TX=1, busy=0, resp=00, resp_rdy=0 throughout.
- snd_cmd with cmd=16'hA53C -> TX shows frame A5 then 3C, LSB first, 4 clocks per bit, no gap between frames. cmd_snt pulses exactly 80 clocks after accept. busy is high over the whole interval.
- After cmd_snt, drive rx_rdy with rx_data=8'hA5 at clock 10 -> resp=A5, resp_rdy=1, clr_rx_rdy pulses 1 cycle, busy drops the next cycle. No timeout pulse.
- No response after cmd_snt -> timeout pulses 50 clocks into WAIT_RESP. resp_rdy stays 0, busy drops.
- snd_cmd re-pulsed with cmd=16'hFFFF during TX_HIGH, and rx_rdy pulsed during TX_LOW -> transmitted bytes are still the original command. The stale byte is cleared via clr_rx_rdy and resp is unchanged.
- rst_n asserted mid-low-byte -> TX=1 immediately, no cmd_snt. After release, a new command 16'h0001 transmits correctly.

Source files
------------

// File: rtl/uart_cmd_sender_if.sv
// Host-side command link bundle: command request/status toward the host and the
// serial TX line plus the byte-receiver handshake toward the robot link.
interface uart_cmd_sender_if;
    logic [15:0] cmd;
    logic        snd_cmd;
    logic        TX;
    logic        rx_rdy;
    logic [7:0]  rx_data;
    logic        clr_rx_rdy;
    logic        busy;
    logic        cmd_snt;
    logic [7:0]  resp;
    logic        resp_rdy;
    logic        timeout;

    modport master (
        output cmd, snd_cmd, rx_rdy, rx_data,
        input  TX, clr_rx_rdy, busy, cmd_snt, resp, resp_rdy, timeout
    );

    modport slave (
        input  cmd, snd_cmd, rx_rdy, rx_data,
        output TX, clr_rx_rdy, busy, cmd_snt, resp, resp_rdy, timeout
    );
endinterface

// File: rtl/uart_cmd_sender.sv
// Sends a 16-bit command as two back-to-back 8N1 frames (high byte first) and
// then waits a bounded time for a single response byte from the byte receiver.
module uart_cmd_sender #(
    parameter int BAUD_DIV     = 2604,
    parameter int RESP_TIMEOUT = 1000000
) (
    input  logic             clk,
    input  logic             rst_n,
    uart_cmd_sender_if.slave bus
);
    localparam int BAUD_W = $clog2(BAUD_DIV);
    localparam int TMO_W  = $clog2(RESP_TIMEOUT + 1);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BAUD_DIV - 1);
    localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(RESP_TIMEOUT - 1);
    localparam logic [3:0]        STOP_IDX  = 4'd9;

    typedef enum logic [1:0] {IDLE, TX_HIGH, TX_LOW, WAIT_RESP} state_t;

    state_t            state_q, state_d;
    logic [15:0]       cmd_buf_q, cmd_buf_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [3:0]        bit_q, bit_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic              tx_q, tx_d;
    logic              busy_q, busy_d;
    logic              cmd_snt_q, cmd_snt_d;
    logic [7:0]        resp_q, resp_d;
    logic              resp_rdy_q, resp_rdy_d;
    logic              timeout_q, timeout_d;
    logic              clr_q, clr_d;
    logic [7:0]        cur_byte;
    logic              rx_take;

    // Frame position 0 is the start bit, 1..8 are data LSB first, 9 is stop.
    function automatic logic frame_bit(input logic [7:0] data, input logic [3:0] idx);
        if (idx == 4'd0)
            return 1'b0;
        else if (idx >= STOP_IDX)
            return 1'b1;
        else
            return data[3'(idx - 4'd1)];
    endfunction

    always_comb begin
        state_d    = state_q;
        cmd_buf_d  = cmd_buf_q;
        baud_d     = baud_q;
        bit_d      = bit_q;
        tmo_d      = tmo_q;
        tx_d       = tx_q;
        busy_d     = busy_q;
        resp_d     = resp_q;
        resp_rdy_d = resp_rdy_q;
        cmd_snt_d  = 1'b0;
        timeout_d  = 1'b0;
        // The receiver only drops rx_rdy on the edge after our pulse, so a byte
        // already acknowledged last cycle must not be taken or acked again.
        rx_take    = bus.rx_rdy & ~clr_q;
        clr_d      = rx_take;
        cur_byte   = (state_q == TX_HIGH) ? cmd_buf_q[15:8] : cmd_buf_q[7:0];

        case (state_q)
            IDLE: begin
                if (bus.snd_cmd) begin
                    cmd_buf_d  = bus.cmd;
                    resp_rdy_d = 1'b0;
                    state_d    = TX_HIGH;
                    tx_d       = 1'b0;
                    busy_d     = 1'b1;
                    baud_d     = '0;
                    bit_d      = '0;
                end
            end
            TX_HIGH, TX_LOW: begin
                if (baud_q == BAUD_LAST) begin
                    baud_d = '0;
                    if (bit_q == STOP_IDX) begin
                        bit_d = '0;
                        if (state_q == TX_HIGH) begin
                            state_d = TX_LOW;
                            tx_d    = 1'b0;
                        end else begin
                            state_d   = WAIT_RESP;
                            tx_d      = 1'b1;
                            cmd_snt_d = 1'b1;
                            tmo_d     = '0;
                        end
                    end else begin
                        bit_d = bit_q + 4'd1;
                        tx_d  = frame_bit(cur_byte, bit_q + 4'd1);
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            WAIT_RESP: begin
                tmo_d = tmo_q + 1'b1;
                if (rx_take) begin
                    resp_d     = bus.rx_data;
                    resp_rdy_d = 1'b1;
                    state_d    = IDLE;
                    busy_d     = 1'b0;
                    tmo_d      = '0;
                end else if (tmo_q == TMO_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = IDLE;
                    busy_d    = 1'b0;
                    tmo_d     = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            baud_q     <= '0;
            bit_q      <= '0;
            tmo_q      <= '0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            cmd_snt_q  <= 1'b0;
            resp_q     <= 8'h00;
            resp_rdy_q <= 1'b0;
            timeout_q  <= 1'b0;
            clr_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_q      <= bit_d;
            tmo_q      <= tmo_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            cmd_snt_q  <= cmd_snt_d;
            resp_q     <= resp_d;
            resp_rdy_q <= resp_rdy_d;
            timeout_q  <= timeout_d;
            clr_q      <= clr_d;
        end
    end

    // Command buffer is pure data and is always loaded before it is read.
    always_ff @(posedge clk) begin
        cmd_buf_q <= cmd_buf_d;
    end

    assign bus.TX         = tx_q;
    assign bus.busy       = busy_q;
    assign bus.cmd_snt    = cmd_snt_q;
    assign bus.resp       = resp_q;
    assign bus.resp_rdy   = resp_rdy_q;
    assign bus.timeout    = timeout_q;
    assign bus.clr_rx_rdy = clr_q;
endmodule

// File: tb/tb_uart_cmd_sender.sv
// Scoreboard bench for uart_cmd_sender: stimulus queues expected TX bytes and
// completion events; independent monitors decode TX and pop/compare events.
module tb_uart_cmd_sender;
    localparam int BD = 4;
    localparam int RT = 50;
    localparam int EV_SNT  = 0;
    localparam int EV_RESP = 1;
    localparam int EV_TMO  = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    uart_cmd_sender_if u();

    uart_cmd_sender #(.BAUD_DIV(BD), .RESP_TIMEOUT(RT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (u.slave)
    );

    typedef struct {
        int         kind;
        logic [7:0] val;
    } ev_t;

    ev_t        exp_ev[$];
    logic [7:0] exp_bytes[$];

    int cyc = 0;
    int n_chk = 0;
    int n_pass = 0;
    int snt_cnt = 0;
    int clr_cnt = 0;
    int rst_epoch = 0;
    int acc_edge = 0;
    int snt_edge = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        n_chk++;
        if (act === want) n_pass++;
        else $display("FAIL %s: got %0h, want %0h", name, act, want);
    endtask

    task automatic push_ev(input int kind, input logic [7:0] val);
        ev_t e;
        e.kind = kind;
        e.val  = val;
        exp_ev.push_back(e);
    endtask

    task automatic next_ev(input int kind, output ev_t e, output bit ok);
        ok = 1'b0;
        e.kind = -1;
        e.val  = 8'h00;
        if (exp_ev.size() == 0) begin
            n_chk++;
            $display("FAIL unexpected_event: got kind %0d, want none", kind);
        end else begin
            e = exp_ev.pop_front();
            chk("event_kind", e.kind, kind);
            ok = (e.kind == kind);
        end
    endtask

    // Event monitor: cmd_snt, timeout and response completion.
    initial begin
        logic resp_rdy_prev;
        ev_t  e;
        bit   ok;
        resp_rdy_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                resp_rdy_prev = 1'b0;
            end else begin
                if (u.clr_rx_rdy) clr_cnt++;
                if (u.cmd_snt) begin
                    snt_cnt++;
                    next_ev(EV_SNT, e, ok);
                    chk("cmd_snt_latency", cyc - acc_edge, 20 * BD);
                    snt_edge = cyc;
                end
                if (u.timeout) begin
                    next_ev(EV_TMO, e, ok);
                    chk("timeout_latency", cyc - snt_edge, RT);
                    chk("timeout_resp_rdy", u.resp_rdy, 0);
                    chk("timeout_busy", u.busy, 0);
                end
                if (u.resp_rdy && !resp_rdy_prev) begin
                    next_ev(EV_RESP, e, ok);
                    if (ok) chk("resp_value", u.resp, e.val);
                    chk("resp_clr_pulse", u.clr_rx_rdy, 1);
                    chk("resp_busy_low", u.busy, 0);
                    chk("resp_no_timeout", u.timeout, 0);
                end
                resp_rdy_prev = u.resp_rdy;
            end
        end
    end

    // TX monitor: decodes each 8N1 frame, sampling one clock into every bit.
    initial begin
        logic       tx_prev;
        logic [7:0] d;
        logic [7:0] want;
        logic       stop_b;
        int         ep;
        tx_prev = 1'b1;
        forever begin
            @(negedge clk);
            if (rst_n && tx_prev && !u.TX) begin
                ep = rst_epoch;
                d  = 8'h00;
                @(negedge clk);
                for (int b = 1; b <= 8; b++) begin
                    repeat (BD) @(negedge clk);
                    d[b-1] = u.TX;
                end
                repeat (BD) @(negedge clk);
                stop_b = u.TX;
                if (ep == rst_epoch) begin
                    if (exp_bytes.size() == 0) begin
                        n_chk++;
                        $display("FAIL unexpected_tx_byte: got %0h, want none", d);
                    end else begin
                        want = exp_bytes.pop_front();
                        chk("tx_byte", d, want);
                        chk("tx_stop_bit", stop_b, 1);
                    end
                end
            end
            tx_prev = u.TX;
        end
    end

    task automatic send_cmd(input logic [15:0] c);
        @(negedge clk);
        u.cmd     = c;
        u.snd_cmd = 1'b1;
        acc_edge  = cyc + 1;
        exp_bytes.push_back(c[15:8]);
        exp_bytes.push_back(c[7:0]);
        push_ev(EV_SNT, 8'h00);
        @(negedge clk);
        u.snd_cmd = 1'b0;
        chk("busy_rise", u.busy, 1);
    endtask

    task automatic send_rx(input logic [7:0] b, input bit is_resp);
        bit seen;
        seen = 1'b0;
        if (is_resp) push_ev(EV_RESP, b);
        u.rx_data = b;
        u.rx_rdy  = 1'b1;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (u.clr_rx_rdy) seen = 1'b1;
        end
        chk("clr_rx_rdy_seen", seen, 1);
        @(posedge clk);
        #1 u.rx_rdy = 1'b0;
    endtask

    task automatic wait_snt();
        int start;
        start = snt_cnt;
        for (int i = 0; i < 300 && snt_cnt == start; i++) @(negedge clk);
        chk("cmd_snt_seen", snt_cnt, start + 1);
    endtask

    task automatic wait_idle(input int lim);
        for (int i = 0; i < lim && u.busy; i++) @(negedge clk);
        chk("return_to_idle", u.busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, want finish");
        $fatal(1);
    end

    initial begin
        int lows;
        int clr0;
        int s0;
        u.cmd = 16'h0000;
        u.snd_cmd = 1'b0;
        u.rx_rdy = 1'b0;
        u.rx_data = 8'h00;

        // Reset state, during and after reset
        repeat (3) @(negedge clk);
        chk("rst_tx", u.TX, 1);
        chk("rst_busy", u.busy, 0);
        chk("rst_resp", u.resp, 8'h00);
        chk("rst_resp_rdy", u.resp_rdy, 0);
        chk("rst_cmd_snt", u.cmd_snt, 0);
        chk("rst_timeout", u.timeout, 0);
        chk("rst_clr", u.clr_rx_rdy, 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_tx", u.TX, 1);
        chk("idle_busy", u.busy, 0);

        // A53C, busy held across both frames, response A5
        send_cmd(16'hA53C);
        lows = 0;
        for (int i = 0; i < 20 * BD - 1; i++) begin
            @(negedge clk);
            if (!u.busy) lows++;
        end
        chk("busy_hold_low_cycles", lows, 0);
        wait_snt();
        clr0 = clr_cnt;
        repeat (9) @(negedge clk);
        send_rx(8'hA5, 1'b1);
        wait_idle(20);
        repeat (3) @(negedge clk);
        chk("resp_clr_once", clr_cnt - clr0, 1);
        chk("resp_rdy_held", u.resp_rdy, 1);
        chk("resp_held", u.resp, 8'hA5);

        // No response: timeout, resp kept, resp_rdy cleared by accept
        send_cmd(16'h5AC3);
        push_ev(EV_TMO, 8'h00);
        wait_snt();
        wait_idle(RT + 20);
        chk("tmo_resp_rdy_low", u.resp_rdy, 0);
        chk("tmo_resp_kept", u.resp, 8'hA5);

        // Ignored re-send in TX_HIGH and stale byte in TX_LOW
        send_cmd(16'h1E81);
        repeat (10) @(negedge clk);
        u.cmd = 16'hFFFF;
        u.snd_cmd = 1'b1;
        @(negedge clk);
        u.snd_cmd = 1'b0;
        u.cmd = 16'h0000;
        repeat (40) @(negedge clk);
        clr0 = clr_cnt;
        send_rx(8'h77, 1'b0);
        @(negedge clk);
        chk("stale_clr_once", clr_cnt - clr0, 1);
        chk("stale_resp_kept", u.resp, 8'hA5);
        chk("stale_resp_rdy_low", u.resp_rdy, 0);
        chk("stale_busy", u.busy, 1);
        wait_snt();
        repeat (3) @(negedge clk);
        send_rx(8'h42, 1'b1);
        wait_idle(20);

        // Reset in the middle of the low byte
        send_cmd(16'hC35A);
        repeat (55) @(negedge clk);
        #2;
        rst_epoch++;
        s0 = snt_cnt;
        rst_n = 1'b0;
        #1;
        chk("async_rst_tx", u.TX, 1);
        chk("async_rst_busy", u.busy, 0);
        exp_bytes.delete();
        exp_ev.delete();
        repeat (3) @(negedge clk);
        chk("rst_resp_cleared", u.resp, 8'h00);
        rst_n = 1'b1;
        repeat (100) @(negedge clk);
        chk("no_cmd_snt_after_rst", snt_cnt, s0);
        chk("post_rst_tx_idle", u.TX, 1);

        // Fresh command after reset
        send_cmd(16'h0001);
        push_ev(EV_TMO, 8'h00);
        wait_snt();
        wait_idle(RT + 20);

        repeat (5) @(negedge clk);
        chk("tx_bytes_left", exp_bytes.size(), 0);
        chk("events_left", exp_ev.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
